tlul_dev_adapter: RTL and testbench
===================================

# tlul_dev_adapter

TL-UL device-side responder that terminates one crossbar device port and drives a simple single-outstanding register bus into a peripheral (GPIO, LDO, DCDC, PLL, TSEN, DAP, PLIC). It accepts A-channel requests, checks them, runs a variable-latency register access with a timeout, and returns exactly one D-channel response per request. One instance sits between each crossbar device port and its peripheral's register file.

## Interface
- BaseAddr, 32'h4008_0000: device base address; must equal the crossbar's address-space entry for this device.
- AddrMask, 32'h0000_FFFF: in-device offset mask; `a_address & ~AddrMask` must equal BaseAddr.
- TimeoutCycles, 16: ACCESS cycles without `reg_ack_i` before an error response is returned; legal range 1..65535.
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous and active-high.
- tl_i  in  tlul_pkg::tl_h2d_t  A channel and d_ready. Fields used: a_valid, a_opcode, a_size, a_source, a_address, a_data, a_mask, d_ready.
- tl_o  out  tlul_pkg::tl_d2h_t  D channel and a_ready. Fields driven: a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error; all other fields are 0.
- reg_req_o  out  1  register access request; held high until acknowledged or timed out.
- reg_we_o  out  1  1 = write, 0 = read.
- reg_addr_o  out  32  `a_address & AddrMask`, word-aligned (bits [1:0] forced to 0).
- reg_wdata_o  out  32  write data.
- reg_be_o  out  4  byte enables (a_mask).
- reg_rdata_i  in  32  read data; valid when reg_ack_i is high.
- reg_error_i  in  1  peripheral error; valid when reg_ack_i is high.
- reg_ack_i  in  1  access complete; may be asserted in the first cycle that reg_req_o is high.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE: a_ready = 1, except a_ready = 0 while rst_i is high.
  - On a_valid, capture the request (opcode, size, source, address, data, mask) and run the error check.
  - Error request: go to RESP with the error flag set. No register access is made.
  - Clean request: go to ACCESS.
- Error check (request flagged if any condition holds):
  - a_opcode is not Get(4), PutFullData(0) or PutPartialData(1).
  - a_size > 2.
  - Address is misaligned for a_size.
  - Address is out of region: `(a_address & ~AddrMask) != BaseAddr`.
  - PutFullData mask is not the full mask for the size/offset (size 2 requires 4'hF).
  - a_mask is 0 for a write.
- ACCESS:
  - reg_req_o = 1 and the reg_* outputs are stable from the captured request.
  - Timeout counter starts at 0 on entry and increments each cycle without ack.
  - On reg_ack_i: capture reg_rdata_i and reg_error_i, go to RESP.
  - On counter == TimeoutCycles-1 with no ack: set the error flag, go to RESP.
  - reg_ack_i is ignored outside ACCESS.
- RESP: d_valid = 1; all D fields are held stable until d_ready is sampled high, then go to IDLE.
  - d_opcode: AccessAckData(1) for Get, AccessAck(0) for puts and for rejected non-Get requests.
  - d_size and d_source echo the request.
  - d_data: captured read data for a clean read; 32'hFFFF_FFFF on an errored read; 0 for writes.
  - d_error = check error | reg_error_i | timeout.

## Timing
- Reset values: d_valid = 0, reg_req_o = 0, reg_we_o = 0, reg_addr_o = 0, reg_wdata_o = 0, reg_be_o = 0, all D fields = 0, timeout counter = 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from tl_i to tl_o or from reg_ack_i to tl_o.
- Clean request, ack in the first ACCESS cycle, d_ready held high:
  - A handshake at cycle 0, reg_req_o high at cycle 1, d_valid at cycle 2, a_ready high again at cycle 3.
  - Peak throughput is 1 request per 3 cycles.
- Errored request: d_valid at cycle 1.
- Timeout: d_valid exactly TimeoutCycles+1 cycles after the A handshake.
- Only one transaction is outstanding; a_valid arriving during ACCESS or RESP is back-pressured.
- rst_i mid-transaction: the next cycle is IDLE with every output at its reset value. The in-flight response is dropped; no partial D beat is issued.

## Structure
- Opcode constants and the h2d/d2h structs come from tlul_pkg.
- Per-device BaseAddr and AddrMask values come from the crossbar package (ADDR_SPACE_*, ADDR_MASK_*) at instantiation.
- The state enum is local to the module.
- One natural sub-module: tlul_dev_req_chk, a combinational request checker. Inputs: opcode, size, address, mask, BaseAddr, AddrMask. Output: err.

## Test plan
- Get at 0x4008_0004, ack in the first ACCESS cycle with rdata 0xDEAD_BEEF -> d_valid at cycle 2, AccessAckData, d_data 0xDEAD_BEEF, d_error 0, d_source echoed.
- PutPartialData at 0x4008_0002, size 1, mask 4'b1100, data 0xABCD_0000 -> reg_we_o 1, reg_addr_o 0x0, reg_be_o 4'hC; on ack, AccessAck with d_error 0.
- Get at 0x4009_0000 (out of region), and separately a Get with size 2 at 0x4008_0001 -> no reg_req_o; d_valid at cycle 1, d_error 1, d_data 0xFFFF_FFFF.
- TimeoutCycles = 4, reg_ack_i never asserted -> reg_req_o high for exactly 4 cycles; d_error 1; a later late ack is ignored.
- d_ready held low for 5 cycles in RESP with a_valid high -> D fields stable, a_ready 0, and exactly one response per request.
- rst_i asserted in ACCESS -> next cycle reg_req_o 0, d_valid 0, a_ready 1 after rst_i drops, and no stale response is issued.

Source files
------------

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel structs and opcode constants shared by device adapters
package tlul_pkg;

    localparam logic [2:0] OP_PUT_FULL       = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL    = 3'd1;
    localparam logic [2:0] OP_GET            = 3'd4;
    localparam logic [2:0] OP_ACCESS_ACK     = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DAT = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_dev_req_chk.sv
// rtl/tlul_dev_req_chk.sv - combinational legality check of a TL-UL A-channel request
module tlul_dev_req_chk
    import tlul_pkg::*;
(
    input  logic [2:0]  opcode,
    input  logic [1:0]  size,
    input  logic [31:0] address,
    input  logic [3:0]  mask,
    input  logic [31:0] base_addr,
    input  logic [31:0] addr_mask,
    output logic        err
);

    logic       is_write;
    logic       bad_op;
    logic       bad_size;
    logic       misaligned;
    logic       out_of_region;
    logic       bad_full_mask;
    logic       empty_write;
    logic [3:0] full_mask;

    always_comb begin
        is_write   = (opcode == OP_PUT_FULL) || (opcode == OP_PUT_PARTIAL);
        bad_op     = !(is_write || (opcode == OP_GET));
        bad_size   = (size > 2'd2);
        misaligned = 1'b0;
        full_mask  = 4'hF;
        case (size)
            2'd0: full_mask = 4'b0001 << address[1:0];
            2'd1: begin
                misaligned = address[0];
                full_mask  = 4'b0011 << {address[1], 1'b0};
            end
            default: misaligned = |address[1:0];
        endcase
        out_of_region = ((address & ~addr_mask) != base_addr);
        bad_full_mask = (opcode == OP_PUT_FULL) && (mask != full_mask);
        empty_write   = is_write && (mask == 4'h0);
        err = bad_op | bad_size | misaligned | out_of_region | bad_full_mask | empty_write;
    end

endmodule

// File: rtl/tlul_dev_adapter.sv
// rtl/tlul_dev_adapter.sv - TL-UL device responder driving a single-outstanding register bus
module tlul_dev_adapter
    import tlul_pkg::*;
#(
    parameter logic [31:0] BaseAddr      = 32'h4008_0000,
    parameter logic [31:0] AddrMask      = 32'h0000_FFFF,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  tl_h2d_t     tl_i,
    output tl_d2h_t     tl_o,
    output logic        reg_req_o,
    output logic        reg_we_o,
    output logic [31:0] reg_addr_o,
    output logic [31:0] reg_wdata_o,
    output logic [3:0]  reg_be_o,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_error_i,
    input  logic        reg_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic [15:0] TMO_LAST = 16'(TimeoutCycles - 1);

    state_e      state_q;
    logic [15:0] tmo_cnt_q;
    logic        req_get_q;
    logic [1:0]  req_size_q;
    logic [7:0]  req_source_q;
    logic        d_valid_q;
    logic [2:0]  d_opcode_q;
    logic [1:0]  d_size_q;
    logic [7:0]  d_source_q;
    logic [31:0] d_data_q;
    logic        d_error_q;

    logic        chk_err;
    logic        a_is_get;
    logic        acc_done;
    logic        acc_err;

    tlul_dev_req_chk u_req_chk (
        .opcode    (tl_i.a_opcode),
        .size      (tl_i.a_size),
        .address   (tl_i.a_address),
        .mask      (tl_i.a_mask),
        .base_addr (BaseAddr),
        .addr_mask (AddrMask),
        .err       (chk_err)
    );

    assign a_is_get = (tl_i.a_opcode == OP_GET);
    // A missing ack at the last counted cycle is a timeout and reports as an error.
    assign acc_done = reg_ack_i || (tmo_cnt_q == TMO_LAST);
    assign acc_err  = reg_ack_i ? reg_error_i : 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            tmo_cnt_q    <= '0;
            req_get_q    <= 1'b0;
            req_size_q   <= '0;
            req_source_q <= '0;
            d_valid_q    <= 1'b0;
            d_opcode_q   <= '0;
            d_size_q     <= '0;
            d_source_q   <= '0;
            d_data_q     <= '0;
            d_error_q    <= 1'b0;
            reg_req_o    <= 1'b0;
            reg_we_o     <= 1'b0;
            reg_addr_o   <= '0;
            reg_wdata_o  <= '0;
            reg_be_o     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tl_i.a_valid) begin
                        req_get_q    <= a_is_get;
                        req_size_q   <= tl_i.a_size;
                        req_source_q <= tl_i.a_source;
                        if (chk_err) begin
                            state_q    <= RESP;
                            d_valid_q  <= 1'b1;
                            d_opcode_q <= a_is_get ? OP_ACCESS_ACK_DAT : OP_ACCESS_ACK;
                            d_size_q   <= tl_i.a_size;
                            d_source_q <= tl_i.a_source;
                            d_data_q   <= a_is_get ? 32'hFFFF_FFFF : 32'h0;
                            d_error_q  <= 1'b1;
                        end else begin
                            state_q     <= ACCESS;
                            tmo_cnt_q   <= '0;
                            reg_req_o   <= 1'b1;
                            reg_we_o    <= !a_is_get;
                            reg_addr_o  <= {tl_i.a_address[31:2] & AddrMask[31:2], 2'b00};
                            reg_wdata_o <= tl_i.a_data;
                            reg_be_o    <= tl_i.a_mask;
                        end
                    end
                end
                ACCESS: begin
                    if (acc_done) begin
                        state_q    <= RESP;
                        reg_req_o  <= 1'b0;
                        d_valid_q  <= 1'b1;
                        d_opcode_q <= req_get_q ? OP_ACCESS_ACK_DAT : OP_ACCESS_ACK;
                        d_size_q   <= req_size_q;
                        d_source_q <= req_source_q;
                        d_error_q  <= acc_err;
                        if (!req_get_q) begin
                            d_data_q <= 32'h0;
                        end else if (acc_err) begin
                            d_data_q <= 32'hFFFF_FFFF;
                        end else begin
                            d_data_q <= reg_rdata_i;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                RESP: begin
                    if (tl_i.d_ready) begin
                        state_q    <= IDLE;
                        d_valid_q  <= 1'b0;
                        d_opcode_q <= '0;
                        d_size_q   <= '0;
                        d_source_q <= '0;
                        d_data_q   <= '0;
                        d_error_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = (state_q == IDLE) && !rst_i;
        tl_o.d_valid  = d_valid_q;
        tl_o.d_opcode = d_opcode_q;
        tl_o.d_size   = d_size_q;
        tl_o.d_source = d_source_q;
        tl_o.d_data   = d_data_q;
        tl_o.d_error  = d_error_q;
    end

endmodule

// File: tb/tb_tlul_dev_adapter.sv
// tb/tb_tlul_dev_adapter.sv - directed self-checking bench for tlul_dev_adapter
module tb_tlul_dev_adapter;
    import tlul_pkg::*;

    logic        clk;
    logic        rst_i;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        reg_req;
    logic        reg_we;
    logic [31:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_error;
    logic        reg_ack;

    int checks = 0;
    int errors = 0;
    int resp_count = 0;
    int exp_resp = 0;

    tlul_dev_adapter #(
        .BaseAddr      (32'h4008_0000),
        .AddrMask      (32'h0000_FFFF),
        .TimeoutCycles (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .tl_i        (tl_i),
        .tl_o        (tl_o),
        .reg_req_o   (reg_req),
        .reg_we_o    (reg_we),
        .reg_addr_o  (reg_addr),
        .reg_wdata_o (reg_wdata),
        .reg_be_o    (reg_be),
        .reg_rdata_i (reg_rdata),
        .reg_error_i (reg_error),
        .reg_ack_i   (reg_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_i && tl_o.d_valid && tl_i.d_ready) resp_count <= resp_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                        input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_size    = size;
        tl_i.a_source  = src;
        tl_i.a_address = addr;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        exp_resp++;
    endtask

    initial begin
        tl_i      = '0;
        reg_rdata = '0;
        reg_error = 1'b0;
        reg_ack   = 1'b0;
        rst_i     = 1'b1;
        tick();
        tick();
        chk("rst_a_ready", tl_o.a_ready, 0);
        chk("rst_d_valid", tl_o.d_valid, 0);
        chk("rst_reg_req", reg_req, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_d_data", tl_o.d_data, 0);
        rst_i = 1'b0;
        tl_i.d_ready = 1'b1;
        #1;
        chk("idle_a_ready", tl_o.a_ready, 1);

        // Get with ack in the first access cycle
        send(OP_GET, 2'd2, 8'd5, 32'h4008_0004, 4'hF, 32'h0);
        tick();
        tl_i.a_valid = 1'b0;
        chk("get_reg_req", reg_req, 1);
        chk("get_reg_we", reg_we, 0);
        chk("get_reg_addr", reg_addr, 32'h4);
        chk("get_dvalid_c1", tl_o.d_valid, 0);
        reg_ack = 1'b1;
        reg_rdata = 32'hDEAD_BEEF;
        tick();
        reg_ack = 1'b0;
        chk("get_d_valid", tl_o.d_valid, 1);
        chk("get_d_opcode", tl_o.d_opcode, 1);
        chk("get_d_data", tl_o.d_data, 32'hDEAD_BEEF);
        chk("get_d_error", tl_o.d_error, 0);
        chk("get_d_source", tl_o.d_source, 5);
        chk("get_d_size", tl_o.d_size, 2);
        chk("get_a_ready_resp", tl_o.a_ready, 0);
        chk("get_reg_req_off", reg_req, 0);
        tick();
        chk("get_done_dvalid", tl_o.d_valid, 0);
        chk("get_done_a_ready", tl_o.a_ready, 1);

        // PutPartialData with one wait cycle before ack
        send(OP_PUT_PARTIAL, 2'd1, 8'd7, 32'h4008_0002, 4'hC, 32'hABCD_0000);
        tick();
        tl_i.a_valid = 1'b0;
        chk("pp_reg_req", reg_req, 1);
        chk("pp_reg_we", reg_we, 1);
        chk("pp_reg_addr", reg_addr, 32'h0);
        chk("pp_reg_be", reg_be, 4'hC);
        chk("pp_reg_wdata", reg_wdata, 32'hABCD_0000);
        tick();
        chk("pp_wait_req", reg_req, 1);
        chk("pp_wait_dvalid", tl_o.d_valid, 0);
        reg_ack = 1'b1;
        reg_rdata = 32'h1234_5678;
        tick();
        reg_ack = 1'b0;
        chk("pp_d_valid", tl_o.d_valid, 1);
        chk("pp_d_opcode", tl_o.d_opcode, 0);
        chk("pp_d_error", tl_o.d_error, 0);
        chk("pp_d_data", tl_o.d_data, 0);
        chk("pp_d_source", tl_o.d_source, 7);
        tick();

        // Rejected requests answer in the next cycle without a register access
        send(OP_GET, 2'd2, 8'd1, 32'h4009_0000, 4'hF, 32'h0);
        tick();
        tl_i.a_valid = 1'b0;
        chk("oor_reg_req", reg_req, 0);
        chk("oor_d_valid", tl_o.d_valid, 1);
        chk("oor_d_error", tl_o.d_error, 1);
        chk("oor_d_data", tl_o.d_data, 32'hFFFF_FFFF);
        chk("oor_d_opcode", tl_o.d_opcode, 1);
        tick();
        send(OP_GET, 2'd2, 8'd2, 32'h4008_0001, 4'hF, 32'h0);
        tick();
        tl_i.a_valid = 1'b0;
        chk("mis_reg_req", reg_req, 0);
        chk("mis_d_valid", tl_o.d_valid, 1);
        chk("mis_d_error", tl_o.d_error, 1);
        chk("mis_d_data", tl_o.d_data, 32'hFFFF_FFFF);
        tick();
        send(3'd3, 2'd2, 8'd3, 32'h4008_0000, 4'hF, 32'h0);
        tick();
        tl_i.a_valid = 1'b0;
        chk("badop_d_error", tl_o.d_error, 1);
        chk("badop_d_opcode", tl_o.d_opcode, 0);
        chk("badop_d_data", tl_o.d_data, 0);
        tick();
        send(OP_PUT_FULL, 2'd2, 8'd4, 32'h4008_0000, 4'h7, 32'h0);
        tick();
        tl_i.a_valid = 1'b0;
        chk("pfmask_reg_req", reg_req, 0);
        chk("pfmask_d_error", tl_o.d_error, 1);
        tick();
        send(OP_PUT_PARTIAL, 2'd2, 8'd4, 32'h4008_0000, 4'h0, 32'h0);
        tick();
        tl_i.a_valid = 1'b0;
        chk("nomask_d_error", tl_o.d_error, 1);
        tick();

        // Timeout after exactly four access cycles
        send(OP_GET, 2'd2, 8'd6, 32'h4008_0008, 4'hF, 32'h0);
        tick();
        tl_i.a_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("tmo_req_c%0d", i), reg_req, 1);
            chk($sformatf("tmo_dvalid_c%0d", i), tl_o.d_valid, 0);
            tick();
        end
        chk("tmo_req_end", reg_req, 0);
        chk("tmo_d_valid", tl_o.d_valid, 1);
        chk("tmo_d_error", tl_o.d_error, 1);
        chk("tmo_d_data", tl_o.d_data, 32'hFFFF_FFFF);
        tick();
        reg_ack = 1'b1;
        reg_rdata = 32'h0BAD_0BAD;
        tick();
        reg_ack = 1'b0;
        chk("late_ack_dvalid", tl_o.d_valid, 0);
        chk("late_ack_a_ready", tl_o.a_ready, 1);

        // Back-pressure on D with a_valid held high
        tl_i.d_ready = 1'b0;
        send(OP_GET, 2'd2, 8'd3, 32'h4008_000C, 4'hF, 32'h0);
        tick();
        chk("bp_reg_req", reg_req, 1);
        reg_ack = 1'b1;
        reg_rdata = 32'h1234_5678;
        tick();
        reg_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_dvalid_%0d", i), tl_o.d_valid, 1);
            chk($sformatf("bp_ddata_%0d", i), tl_o.d_data, 32'h1234_5678);
            chk($sformatf("bp_dsrc_%0d", i), tl_o.d_source, 3);
            chk($sformatf("bp_a_ready_%0d", i), tl_o.a_ready, 0);
            chk($sformatf("bp_req_%0d", i), reg_req, 0);
            if (i < 4) tick();
        end
        tl_i.d_ready = 1'b1;
        tick();
        chk("bp_release_dvalid", tl_o.d_valid, 0);
        chk("bp_release_a_ready", tl_o.a_ready, 1);
        send(OP_GET, 2'd2, 8'd9, 32'h4008_0010, 4'hF, 32'h0);
        tick();
        tl_i.a_valid = 1'b0;
        chk("bp2_reg_req", reg_req, 1);
        chk("bp2_reg_addr", reg_addr, 32'h10);
        reg_ack = 1'b1;
        reg_rdata = 32'h0000_55AA;
        tick();
        reg_ack = 1'b0;
        chk("bp2_d_data", tl_o.d_data, 32'h0000_55AA);
        chk("bp2_d_source", tl_o.d_source, 9);
        tick();

        // Reset during ACCESS drops the transaction
        send(OP_GET, 2'd2, 8'd8, 32'h4008_0014, 4'hF, 32'h0);
        exp_resp--;
        tick();
        tl_i.a_valid = 1'b0;
        chk("rsta_reg_req", reg_req, 1);
        rst_i = 1'b1;
        tick();
        chk("rsta_reg_req_off", reg_req, 0);
        chk("rsta_d_valid", tl_o.d_valid, 0);
        chk("rsta_a_ready", tl_o.a_ready, 0);
        rst_i = 1'b0;
        reg_ack = 1'b1;
        #1;
        chk("rsta_a_ready_after", tl_o.a_ready, 1);
        tick();
        reg_ack = 1'b0;
        chk("rsta_no_resp", tl_o.d_valid, 0);
        chk("rsta_reg_req_idle", reg_req, 0);
        tick();
        chk("rsta_no_resp2", tl_o.d_valid, 0);

        chk("resp_count", resp_count, exp_resp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
